rr_arbiter8: RTL and testbench

- Round-robin arbiter that shares one 8-input resource slot among 8 requesters.
- Each cycle it picks one winner using a rotating priority pointer, so the fixed lowest-index bias of a plain 8x3 priority encoder is removed.
- Winner is held while its request stays high, up to a bounded hold time. Then priority rotates past it.
- Sits in front of the shared encoder/datapath and drives its select as a one-hot grant plus a 3-bit index.

---
 rtl/rr_arbiter8_if.sv | 19 +
 rtl/rr_arbiter8.sv | 119 +++++++++++
 tb/tb_rr_arbiter8.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rr_arbiter8_if.sv
// Requester-side bundle of the 8-way round-robin arbiter.
// master drives requests, slave returns the registered grant.
interface rr_arbiter8_if;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;

  modport master (
    output en, req,
    input  gnt, gnt_id, gnt_valid
  );

  modport slave (
    input  en, req,
    output gnt, gnt_id, gnt_valid
  );
endinterface

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with bounded hold.
// Registered one-hot grant plus index; back-to-back hand-off.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter8_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       gnt_q, gnt_d;
  logic             vld_q, vld_d;

  logic        tmo, rel, hit, go;
  logic [2:0]  base, off, win;
  logic [15:0] dbl;
  logic [7:0]  rot;

  assign tmo = (MAX_HOLD != 0) &&
               (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign rel = !bus.en || !bus.req[id_q] || tmo;
  assign hit = |bus.req;
  assign go  = bus.en && hit;

  // On release the holder drops to lowest priority.
  assign base = (state_q == BUSY) ? id_q + 3'd1 : ptr_q;

  always_comb begin
    logic found;
    dbl   = {bus.req, bus.req} >> base;
    rot   = dbl[7:0];
    found = 1'b0;
    off   = 3'd0;
    for (int j = 0; j < 8; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        off   = 3'(j);
      end
    end
    win = base + off;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      id_q    <= 3'd0;
      cnt_q   <= '0;
      gnt_q   <= 8'd0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (go) state_d = BUSY;
      BUSY: if (rel && !go) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    id_d  = id_q;
    cnt_d = cnt_q;
    gnt_d = gnt_q;
    vld_d = vld_q;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          gnt_d = 8'd1 << win;
          id_d  = win;
          vld_d = 1'b1;
          cnt_d = '0;
        end
      end
      BUSY: begin
        if (!rel) begin
          if (MAX_HOLD != 0) cnt_d = cnt_q + 1'b1;
        end else begin
          ptr_d = id_q + 3'd1;
          if (go) begin
            gnt_d = 8'd1 << win;
            id_d  = win;
            vld_d = 1'b1;
            cnt_d = '0;
          end else begin
            gnt_d = 8'd0;
            vld_d = 1'b0;
          end
        end
      end
      default: begin
        gnt_d = 8'd0;
        vld_d = 1'b0;
      end
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = id_q;
  assign bus.gnt_valid = vld_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: three instances cover
// the default, short (4) and unlimited hold configurations.
module tb_rr_arbiter8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_arbiter8_if ifa ();
  rr_arbiter8_if ifb ();
  rr_arbiter8_if ifc ();

  rr_arbiter8 #(.MAX_HOLD(16), .CNT_W(5)) u_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(3)) u_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );
  rr_arbiter8 #(.MAX_HOLD(0), .CNT_W(5)) u_c (
    .clk(clk), .rst(rst), .bus(ifc)
  );

  typedef struct {
    int         sel;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       v;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  int   nchk = 0;
  int   nfail = 0;

  task automatic chk(string tag, logic [7:0] o, logic [7:0] x);
    nchk++;
    assert (o === x) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, x);
    end
  endtask

  task automatic drive(int sel, logic r, logic e, logic [7:0] q);
    rst     = r;
    ifa.en  = (sel == 0) ? e : 1'b0;
    ifa.req = (sel == 0) ? q : 8'h00;
    ifb.en  = (sel == 1) ? e : 1'b0;
    ifb.req = (sel == 1) ? q : 8'h00;
    ifc.en  = (sel == 2) ? e : 1'b0;
    ifc.req = (sel == 2) ? q : 8'h00;
  endtask

  task automatic step(int sel, logic r, logic e, logic [7:0] q,
                      logic v, logic [2:0] id, string tag);
    exp_t x, y;
    logic [7:0] og;
    logic [2:0] oi;
    logic       ov;
    drive(sel, r, e, q);
    x.sel = sel;
    x.v   = v;
    x.id  = id;
    x.gnt = v ? (8'd1 << id) : 8'h00;
    x.tag = tag;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      nchk++;
      nfail++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      y = sbq.pop_front();
      case (y.sel)
        1: begin og = ifb.gnt; oi = ifb.gnt_id; ov = ifb.gnt_valid; end
        2: begin og = ifc.gnt; oi = ifc.gnt_id; ov = ifc.gnt_valid; end
        default: begin og = ifa.gnt; oi = ifa.gnt_id; ov = ifa.gnt_valid; end
      endcase
      chk({y.tag, ".gnt"}, og, y.gnt);
      chk({y.tag, ".id"}, {5'd0, oi}, {5'd0, y.id});
      chk({y.tag, ".vld"}, {7'd0, ov}, {7'd0, y.v});
    end
  endtask

  initial begin
    drive(0, 1'b1, 1'b0, 8'h00);
    @(posedge clk);
    #1;

    // reset dominates en/req, then first grant to 0
    step(0, 1, 1, 8'hFF, 0, 0, "rst0");
    step(0, 1, 1, 8'hFF, 0, 0, "rst1");
    step(0, 0, 1, 8'hFF, 1, 0, "rst_rel");

    // enable gating
    step(0, 1, 0, 8'h00, 0, 0, "rst_t2");
    for (int i = 0; i < 5; i++)
      step(0, 0, 0, 8'hFF, 0, 0, "en_low");
    step(0, 0, 1, 8'hFF, 1, 0, "en_rise");

    // hold and bubble-free hand-off
    step(0, 1, 0, 8'h00, 0, 0, "rst_t3");
    step(0, 0, 1, 8'h14, 1, 2, "hold_first");
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 8'h14, 1, 2, "hold");
    step(0, 0, 1, 8'h10, 1, 4, "handoff");

    // timeout at 7 wraps pointer to 0
    step(0, 1, 0, 8'h00, 0, 0, "rst_t5");
    step(0, 0, 1, 8'h80, 1, 7, "wrap_first");
    for (int i = 0; i < 15; i++)
      step(0, 0, 1, 8'h81, 1, 7, "wrap_hold");
    step(0, 0, 1, 8'h81, 1, 0, "wrap");

    // en abort: index holds, pointer moves past holder
    step(0, 1, 0, 8'h00, 0, 0, "rst_t6a");
    step(0, 0, 1, 8'h08, 1, 3, "g3");
    step(0, 0, 0, 8'hFF, 0, 3, "en_abort");
    step(0, 0, 1, 8'hFF, 1, 4, "after_abort");

    // reset abort
    step(0, 1, 0, 8'h00, 0, 0, "rst_t6b");
    step(0, 0, 1, 8'h20, 1, 5, "g5");
    step(0, 1, 1, 8'h20, 0, 0, "rst_abort");
    step(0, 0, 1, 8'hFF, 1, 0, "after_rst");

    // MAX_HOLD=4 rotation with all requesting
    step(1, 1, 0, 8'h00, 0, 0, "rst_t4");
    for (int k = 0; k < 36; k++)
      step(1, 0, 1, 8'hFF, 1, 3'((k / 4) % 8), "rotate");

    // unlimited hold
    step(2, 1, 0, 8'h00, 0, 0, "rst_t6c");
    for (int k = 0; k < 120; k++)
      step(2, 0, 1, 8'hFF, 1, 0, "nolimit");

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
